upc_tag_serializer: RTL
=======================

// Module: upc_tag_serializer
// PURPOSE
// Scanner-side transmitter for the UPC checker path: takes one item tag (3-bit UPC
// + secret mark) via a valid/ready handshake and sends it as a framed serial word
// on one wire. The matching deserializer presents U,P,C,mark to the checker.
// One frame per item. The tag is latched at accept, so the source may change it freely.
// PARAMETERS
// CLKS_PER_BIT  4  clock cycles per serial bit; legal range >=1 (board builds use 5000)
// PORTS
// clk          in   1  system clock, all state on rising edge
// reset        in   1  asynchronous, active-high reset
// tx_valid     in   1  source has a tag on upc/mark
// tx_ready     out  1  block can accept a tag this cycle
// upc          in   3  {U,P,C}; upc[2]=U, upc[1]=P, upc[0]=C
// mark         in   1  secret mark bit
// tx_line      out  1  serial output, idles high
// busy         out  1  frame in progress (START..STOP)
// frames_sent  out  8  count of completed frames, wraps 255->0
// BEHAVIOUR
// - Reset (async, immediate): state=IDLE, tx_line=1, busy=0, frames_sent=0,
//   bit/cycle counters=0, latched tag=0. tx_ready=1 while in IDLE, including during reset.
// - tx_ready = (state==IDLE), combinational from state only; no dependence on tx_valid.
// - Accept: rising edge with tx_valid && tx_ready. Latch {upc,mark} into shift reg.
//   Compute parity = ^{upc,mark} (even parity over 4 data bits). Go to START.
// - Frame, each bit held exactly CLKS_PER_BIT cycles, in order:
//   START(0), U, P, C, mark, PARITY, STOP(1). Frame length = 7*CLKS_PER_BIT cycles.
// - FSM: IDLE -> START -> DATA (4 bits, MSB first, 2-bit index) -> PARITY -> STOP -> IDLE.
//   Each state advances when cycle counter == CLKS_PER_BIT-1. The counter then clears.
// - tx_line is registered. It is driven low on the first cycle after the accept edge.
// - busy=1 exactly while state != IDLE. tx_ready=0 for the same cycles.
// - frames_sent increments on the edge leaving STOP. 8-bit modulo wrap, no saturation.
// - Back-to-back: the FSM always spends >=1 cycle in IDLE (line high) between frames.
//   With tx_valid held high, consecutive frames are separated by exactly 1 idle cycle.
// - tx_valid/upc/mark changes while busy are ignored. No tag is queued.
// - Reset mid-frame: frame abandoned, line high at once, frames_sent cleared to 0.
//   The next accepted frame is sent normally.
// - CLKS_PER_BIT=1: counter width is at least 1. Each bit lasts 1 cycle. No special cases.
// - No X on outputs after reset. The tx_valid/upc/mark inputs are synchronous to clk.
// TESTING (CLKS_PER_BIT=4)
// 1 Assert reset mid-cycle with no clock -> tx_line=1, tx_ready=1, busy=0, frames_sent=0
//   immediately.
// 2 Pulse tx_valid one cycle, upc=3'b101, mark=0 -> tx_line 0,1,0,1,0,0,1, each 4 cycles
//   (parity 0). Then tx_ready=0 for 28 cycles, busy=1 for 28, frames_sent=1.
// 3 upc=3'b011, mark=1 -> data 0,1,1,1; parity bit=1; stop=1; frames_sent increments by 1.
// 4 Hold tx_valid=1, two tags -> two 28-cycle frames with exactly 1 high idle cycle
//   between them; frames_sent=2.
// 5 Change upc/mark and pulse tx_valid during the DATA state -> transmitted bits match the
//   originally latched tag; no extra frame is sent.
// 6 Assert reset during the 3rd data bit -> tx_line=1 and tx_ready=1 asynchronously,
//   frames_sent=0; next frame is correct. Send 256 frames -> frames_sent wraps to 0.

Source files
------------

// File: rtl/upc_tag_serializer.sv
// Serializes one {U,P,C,mark} tag per valid/ready handshake as a framed word:
// START(0), U, P, C, mark, even parity, STOP(1), each bit CLKS_PER_BIT cycles.
module upc_tag_serializer #(
    parameter int CLKS_PER_BIT = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tx_valid,
    output logic       tx_ready,
    input  logic [2:0] upc,
    input  logic       mark,
    output logic       tx_line,
    output logic       busy,
    output logic [7:0] frames_sent
);

    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    state_t        state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic [1:0]    idx, idx_n;
    logic [3:0]    shreg, sh_n;
    logic          par;
    logic          line_n;
    logic          load;
    logic          done;
    logic          last;

    assign tx_ready = (state == S_IDLE);
    assign busy     = (state != S_IDLE);
    assign last     = (cnt == CW'(CLKS_PER_BIT - 1));

    // line_n is the value the line takes in the state being entered, so the
    // registered line changes on the same edge as the state.
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        idx_n   = idx;
        sh_n    = shreg;
        line_n  = tx_line;
        load    = 1'b0;
        done    = 1'b0;
        case (state)
            S_IDLE: begin
                if (tx_valid) begin
                    state_n = S_START;
                    cnt_n   = '0;
                    line_n  = 1'b0;
                    load    = 1'b1;
                end
            end
            S_START: begin
                if (last) begin
                    state_n = S_DATA;
                    cnt_n   = '0;
                    idx_n   = '0;
                    line_n  = shreg[3];
                end else begin
                    cnt_n = cnt + CW'(1);
                end
            end
            S_DATA: begin
                if (last) begin
                    cnt_n = '0;
                    sh_n  = {shreg[2:0], 1'b0};
                    if (idx == 2'd3) begin
                        state_n = S_PARITY;
                        line_n  = par;
                    end else begin
                        idx_n  = idx + 2'd1;
                        line_n = shreg[2];
                    end
                end else begin
                    cnt_n = cnt + CW'(1);
                end
            end
            S_PARITY: begin
                if (last) begin
                    state_n = S_STOP;
                    cnt_n   = '0;
                    line_n  = 1'b1;
                end else begin
                    cnt_n = cnt + CW'(1);
                end
            end
            S_STOP: begin
                if (last) begin
                    state_n = S_IDLE;
                    cnt_n   = '0;
                    line_n  = 1'b1;
                    done    = 1'b1;
                end else begin
                    cnt_n = cnt + CW'(1);
                end
            end
            default: begin
                state_n = S_IDLE;
                cnt_n   = '0;
                line_n  = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= S_IDLE;
            cnt         <= '0;
            idx         <= '0;
            shreg       <= '0;
            par         <= 1'b0;
            tx_line     <= 1'b1;
            frames_sent <= '0;
        end else begin
            state   <= state_n;
            cnt     <= cnt_n;
            idx     <= idx_n;
            tx_line <= line_n;
            if (load) begin
                shreg <= {upc, mark};
                par   <= ^{upc, mark};
            end else begin
                shreg <= sh_n;
            end
            if (done) begin
                frames_sent <= frames_sent + 8'd1;
            end
        end
    end

endmodule
